// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the fifo read-side drain: default sizes and the
// coarse activity state reported through busy.
package fifo_drain_pkg;

    localparam int DRAIN_DATA_W    = 8;
    localparam int DRAIN_BUF_DEPTH = 3;
    localparam int DRAIN_CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // nothing buffered, nothing requested
        ST_FILL   = 2'd1,   // a read is in flight, buffer still empty
        ST_STREAM = 2'd2    // at least one byte buffered
    } fifo_drain_state_t;

endpackage

// File: rtl/fifo_drain_buf.sv
// Small circular register buffer that absorbs the fifo read latency.
// Pointers wrap at DEPTH by explicit compare so non-power-of-two depths work.
// Storage has no reset; only pointers and occupancy are cleared.
module fifo_drain_buf
    import fifo_drain_pkg::*;
#(
    parameter int DATA_W = DRAIN_DATA_W,
    parameter int DEPTH  = DRAIN_BUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] occ,
    output logic [DATA_W-1:0]          head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave occ alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                occ <= occ + OCC_W'(1);
            else if (!push && pop)
                occ <= occ - OCC_W'(1);
        end
    end

    // Byte storage written at the write pointer; contents are don't-care when empty.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_drain.sv
// Read-side consumer for the synchronous byte fifo. Issues pops from
// registered state only (no m_ready -> fifo_rd_en path), reserves a buffer
// slot for every read in flight, and streams bytes out with valid/ready.
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int DATA_W    = DRAIN_DATA_W,
    parameter int BUF_DEPTH = DRAIN_BUF_DEPTH,
    parameter int CNT_W     = DRAIN_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  drain_cnt,
    output logic              busy
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    logic [OCC_W-1:0]  occ;
    logic [OCC_W:0]    pending;
    logic              inflight;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;
    fifo_drain_state_t state;

    // Buffered bytes plus the one possibly on its way from the fifo.
    assign pending    = {1'b0, occ} + (OCC_W + 1)'(inflight);
    assign fifo_rd_en = !rst && !flush && !fifo_empty
                        && (pending < (OCC_W + 1)'(BUF_DEPTH));

    assign push    = inflight && !flush;
    assign m_valid = (occ != '0);
    assign pop     = m_valid && m_ready && !flush;
    assign m_data  = m_valid ? head : '0;

    fifo_drain_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (push),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    // Track the fifo's one-cycle read latency; flush drops the byte in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            inflight <= 1'b0;
        else if (flush)
            inflight <= 1'b0;
        else
            inflight <= fifo_rd_en;
    end

    // Debug count of completed output handshakes, free-running with wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drain_cnt <= '0;
        else if (pop)
            drain_cnt <= drain_cnt + 1'b1;
    end

    // Activity state derived from occupancy and the in-flight read.
    always_comb begin
        state = ST_IDLE;
        if (occ != '0)
            state = ST_STREAM;
        else if (inflight)
            state = ST_FILL;
    end

    assign busy = (state != ST_IDLE);

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        pending <= (OCC_W + 1)'(BUF_DEPTH));

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: a queue-based fifo model feeds the DUT, and a
// reference model tracks bytes taken from the fifo but not yet consumed.
module tb_fifo_drain;

    localparam int DATA_W    = 8;
    localparam int BUF_DEPTH = 3;
    localparam int CNT_W     = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              flush;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  drain_cnt;
    logic              busy;

    always #5 clk = ~clk;

    fifo_drain #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .drain_cnt    (drain_cnt),
        .busy         (busy)
    );

    int nvec = 0;
    int nmis = 0;

    byte unsigned fq[$];   // fifo contents
    byte unsigned oq[$];   // bytes taken from fifo, not yet handed downstream
    bit           infl;    // newest oq entry still on its way into the DUT
    int unsigned  cnt_m;   // expected handshake count
    bit           last_en;
    bit           last_hs;

    typedef struct {
        bit          rdy;
        bit          fl;
        bit          exp_rd_en;
        bit          exp_vld;
        logic [7:0]  exp_data;
        bit          exp_busy;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fpush(input byte unsigned b);
        fq.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic model_reset();
        oq.delete();
        infl  = 1'b0;
        cnt_m = 0;
    endtask

    task automatic check_model();
        int landed;
        landed = oq.size() - (infl ? 1 : 0);
        chk("rd_en", fifo_rd_en, !flush && !fifo_empty && (oq.size() < BUF_DEPTH));
        chk("rd_en_when_empty", fifo_rd_en && fifo_empty, 0);
        chk("m_valid", m_valid, landed > 0);
        if (landed > 0)
            chk("m_data", m_data, oq[0]);
        chk("busy", busy, oq.size() != 0);
        chk("drain_cnt", drain_cnt, cnt_m[15:0]);
    endtask

    // One clock: check (unless quiet), clock the DUT, then advance fifo and model.
    task automatic step(input bit quiet);
        bit en;
        bit hs;
        bit fl;
        byte unsigned b;
        int landed;
        #1;
        if (!quiet)
            check_model();
        landed = oq.size() - (infl ? 1 : 0);
        en = fifo_rd_en;
        hs = (landed > 0) && m_ready;
        fl = flush;
        b  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        if (en) begin
            if (fq.size() == 0) begin
                chk("pop_of_empty_fifo", 1, 0);
            end else begin
                b = fq.pop_front();
                fifo_rd_data = b;
            end
        end
        fifo_empty = (fq.size() == 0);
        if (fl) begin
            oq.delete();
            infl = 1'b0;
        end else begin
            if (hs) begin
                void'(oq.pop_front());
                cnt_m++;
            end
            if (en)
                oq.push_back(b);
            infl = en;
        end
        last_en = en;
        last_hs = hs;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        flush = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        byte unsigned bytes3[10];
        int pops;
        int first_hs;
        int last_hs_i;
        int nhs;
        int hs_idx;
        int idle_idx;
        bit found;

        rst = 1'b1;
        flush = 1'b0;
        m_ready = 1'b0;
        fifo_empty = 1'b1;
        fifo_rd_data = '0;
        model_reset();

        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h24, 1'b1, 16'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h81, 1'b1, 16'd1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h09, 1'b1, 16'd2};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd3};

        // reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_drain_cnt", drain_cnt, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // three bytes streamed with m_ready held high
        fpush(8'h24); fpush(8'h81); fpush(8'h09);
        for (int i = 0; i < 6; i++) begin
            m_ready = tbl[i].rdy;
            flush   = tbl[i].fl;
            #1;
            chk($sformatf("tbl%0d_rd_en", i), fifo_rd_en, tbl[i].exp_rd_en);
            chk($sformatf("tbl%0d_m_valid", i), m_valid, tbl[i].exp_vld);
            if (tbl[i].exp_vld)
                chk($sformatf("tbl%0d_m_data", i), m_data, tbl[i].exp_data);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
            chk($sformatf("tbl%0d_drain_cnt", i), drain_cnt, tbl[i].exp_cnt);
            step(0);
        end

        // backpressure: ten bytes queued, downstream stalled
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bytes3[i] = byte'($urandom_range(0, 255));
            fpush(bytes3[i]);
        end
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            step(0);
            pops += last_en;
        end
        #1;
        chk("stall_pops", pops, 3);
        chk("stall_m_valid", m_valid, 1);
        chk("stall_m_data", m_data, bytes3[0]);
        chk("stall_rd_en", fifo_rd_en, 0);
        m_ready = 1'b1;
        first_hs = -1;
        last_hs_i = -1;
        nhs = 0;
        for (int i = 0; i < 16; i++) begin
            step(0);
            if (last_hs) begin
                if (first_hs < 0)
                    first_hs = i;
                last_hs_i = i;
                nhs++;
            end
        end
        #1;
        chk("stream_hs_count", nhs, 10);
        chk("stream_hs_span", last_hs_i - first_hs + 1, 10);
        chk("stream_drain_cnt", drain_cnt, 10);

        // single byte, then fifo runs dry
        do_reset();
        fpush(8'h5C);
        m_ready = 1'b1;
        hs_idx = -1;
        idle_idx = -1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (hs_idx >= 0 && idle_idx < 0 && !busy)
                idle_idx = i;
            step(0);
            if (last_hs)
                hs_idx = i;
        end
        chk("single_hs_seen", hs_idx >= 0, 1);
        chk("busy_fall_delay", idle_idx - hs_idx, 1);

        // flush with two buffered bytes and one in flight
        do_reset();
        fpush(8'h11); fpush(8'h22); fpush(8'h33);
        for (int i = 0; i < 3; i++)
            step(0);
        #1;
        chk("pre_flush_m_valid", m_valid, 1);
        chk("pre_flush_busy", busy, 1);
        chk("pre_flush_m_data", m_data, 8'h11);
        flush = 1'b1;
        step(0);
        flush = 1'b0;
        #1;
        chk("post_flush_m_valid", m_valid, 0);
        chk("post_flush_busy", busy, 0);
        chk("post_flush_drain_cnt", drain_cnt, 0);
        fpush(8'hA5);
        m_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (m_valid) begin
                found = 1'b1;
                break;
            end
            step(0);
        end
        chk("flush_next_valid_seen", found, 1);
        chk("flush_next_m_data", m_data, 8'hA5);
        chk("flush_drain_cnt_kept", drain_cnt, 0);
        repeat (3) step(0);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (($urandom % 3) != 0 && fq.size() < 20)
                fpush(byte'($urandom_range(0, 255)));
            m_ready = (($urandom % 4) != 0);
            flush   = (($urandom % 40) == 0);
            step(0);
        end
        flush = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 30; i++)
            step(0);
        fq.delete();
        fifo_empty = 1'b1;

        // counter wrap, then asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 65545; i++)
            fpush(byte'(i));
        m_ready = 1'b1;
        for (int i = 0; i < 70000 && cnt_m != 65535; i++)
            step(1);
        #1;
        chk("cnt_at_ffff", drain_cnt, 16'hFFFF);
        step(0);
        step(0);
        #1;
        chk("cnt_wrapped", drain_cnt, 16'h0001);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_m_valid", m_valid, 0);
        chk("async_rst_m_data", m_data, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_drain_cnt", drain_cnt, 0);
        chk("async_rst_rd_en", fifo_rd_en, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        fq.delete();
        fifo_empty = 1'b1;
        repeat (3) step(0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
